// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD sequencer and byte writer
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_WR,
        S_DELAY,
        S_DONE
    } state_t;

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW_BASE [0:3] = '{8'h00, 8'h40, 8'h14, 8'h54};
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    function automatic logic [7:0] ddram_cmd(input logic [1:0] row);
        return CMD_SET_DDRAM | ROW_BASE[row];
    endfunction

endpackage

// File: rtl/lcd_wait_cnt.sv
// lcd_wait_cnt: loadable down-counter that stops at zero and flags it
module lcd_wait_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load has priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    end

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: walks an init command list or a text buffer into the LCD byte writer
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int INIT_DEPTH = 16,
    parameter int SHORT_WAIT = 2000,
    parameter int LONG_WAIT  = 82000,
    localparam int IW = $clog2(INIT_DEPTH),
    localparam int TW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    input  logic [IW-1:0] init_last,
    output logic [IW-1:0] init_idx,
    input  logic [7:0]    init_byte,
    input  logic          init_long,
    output logic [TW-1:0] text_idx,
    input  logic [7:0]    text_byte,
    output logic [7:0]    wr_data,
    output logic          wr_rs,
    output logic          wr_start,
    input  logic          wr_done,
    output logic          busy,
    output logic          done
);

    localparam int DW = $clog2((SHORT_WAIT > LONG_WAIT ? SHORT_WAIT : LONG_WAIT) + 1);
    localparam logic [DW-1:0] SHORT_LD = DW'(SHORT_WAIT - 1);
    localparam logic [DW-1:0] LONG_LD  = DW'(LONG_WAIT - 1);
    localparam logic [TW-1:0] TXT_LAST = TW'(ROWS * COLS - 1);
    localparam logic [4:0]    COL_LAST = 5'(COLS - 1);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          long_q, long_d;
    logic          addr_pend_q, addr_pend_d;
    logic [IW-1:0] init_last_q, init_last_d;
    logic [IW-1:0] init_idx_q, init_idx_d;
    logic [TW-1:0] text_idx_q, text_idx_d;
    logic [1:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          wr_rs_q, wr_rs_d;
    logic          wr_start_q, wr_start_d;
    logic          cnt_load;
    logic [DW-1:0] cnt_val;
    logic          cnt_zero;

    lcd_wait_cnt #(.W(DW)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // next-state and datapath; abort overrides everything so indices hold
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        long_d      = long_q;
        addr_pend_d = addr_pend_q;
        init_last_d = init_last_q;
        init_idx_d  = init_idx_q;
        text_idx_d  = text_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        wr_data_d   = wr_data_q;
        wr_rs_d     = wr_rs_q;
        wr_start_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = SHORT_LD;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    mode_d      = mode;
                    init_last_d = init_last;
                    init_idx_d  = '0;
                    text_idx_d  = '0;
                    row_d       = '0;
                    col_d       = '0;
                    addr_pend_d = 1'b1;
                    state_d     = S_LOAD;
                end
                S_LOAD: state_d = S_ISSUE;
                S_ISSUE: begin
                    wr_start_d = 1'b1;
                    long_d     = init_long;
                    wr_data_d  = mode_q ? init_byte
                               : (addr_pend_q && col_q == '0) ? ddram_cmd(row_q) : text_byte;
                    wr_rs_d    = (mode_q || (addr_pend_q && col_q == '0)) ? RS_CMD : RS_DATA;
                    state_d    = S_WAIT_WR;
                end
                S_WAIT_WR: if (wr_done && !wr_start_q) begin
                    cnt_load = 1'b1;
                    cnt_val  = (mode_q && long_q) ? LONG_LD : SHORT_LD;
                    state_d  = S_DELAY;
                end
                S_DELAY: if (cnt_zero) begin
                    if (mode_q) begin
                        if (init_idx_q == init_last_q) state_d = S_DONE;
                        else begin
                            init_idx_d = init_idx_q + 1'b1;
                            state_d    = S_LOAD;
                        end
                    end else if (addr_pend_q) begin
                        addr_pend_d = 1'b0;
                        state_d     = S_LOAD;
                    end else if (text_idx_q == TXT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        text_idx_d  = text_idx_q + 1'b1;
                        state_d     = S_LOAD;
                        col_d       = (col_q == COL_LAST) ? 5'd0 : col_q + 1'b1;
                        row_d       = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
                        addr_pend_d = (col_q == COL_LAST);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            long_q      <= 1'b0;
            addr_pend_q <= 1'b0;
            init_last_q <= '0;
            init_idx_q  <= '0;
            text_idx_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wr_data_q   <= '0;
            wr_rs_q     <= 1'b0;
            wr_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            long_q      <= long_d;
            addr_pend_q <= addr_pend_d;
            init_last_q <= init_last_d;
            init_idx_q  <= init_idx_d;
            text_idx_q  <= text_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wr_data_q   <= wr_data_d;
            wr_rs_q     <= wr_rs_d;
            wr_start_q  <= wr_start_d;
        end
    end

    assign init_idx = init_idx_q;
    assign text_idx = text_idx_q;
    assign wr_data  = wr_data_q;
    assign wr_rs    = wr_rs_q;
    assign wr_start = wr_start_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule
